led_fader: RTL and testbench

LED_FADER -- requirements
Module: led_fader

---
 rtl/led_pkg.sv | 10 +
 rtl/led_fade_channel.sv | 40 ++++
 rtl/led_fader.sv | 50 +++++
 tb/tb_led_fader.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// led_pkg: shared PWM resolution default, level ceiling and channel state encoding
package led_pkg;
    localparam int PWM_BITS_DEF = 8;

    typedef enum logic [1:0] {OFF, RISING, ON, FALLING} ch_state_e;

    function automatic int level_max(input int bits);
        return (1 << bits) - 1;
    endfunction
endpackage

// File: rtl/led_fade_channel.sv
// led_fade_channel: one channel's registered target, saturating level ramp and PWM compare
module led_fade_channel
    import led_pkg::*;
#(
    parameter int PWM_BITS = PWM_BITS_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pattern,
    input  logic                tick,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led,
    output logic                ramping
);
    localparam logic [PWM_BITS-1:0] LMAX = PWM_BITS'(level_max(PWM_BITS));

    logic                target;
    logic [PWM_BITS-1:0] level;
    logic [PWM_BITS-1:0] level_nxt;
    ch_state_e           state;

    // state derives from the registered target, so a same-cycle pattern change only affects the next tick
    always_comb begin
        state     = target ? (level == LMAX ? ON : RISING) : (level == '0 ? OFF : FALLING);
        level_nxt = !tick ? level : state == RISING ? level + 1'b1 : state == FALLING ? level - 1'b1 : level;
        ramping   = state == RISING || state == FALLING;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target <= 1'b0;
            level  <= '0;
            led    <= 1'b0;
        end else begin
            target <= pattern;
            level  <= level_nxt;
            led    <= pwm_cnt < level;
        end
    end
endmodule

// File: rtl/led_fader.sv
// led_fader: N_CH independent LED faders sharing a free-running PWM counter and ramp prescaler
module led_fader
    import led_pkg::*;
#(
    parameter int N_CH     = 5,
    parameter int PWM_BITS = PWM_BITS_DEF,
    parameter int RAMP_DIV = 11719
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] pattern_in,
    input  logic            enable,
    output logic [N_CH-1:0] led_out,
    output logic            busy
);
    localparam logic [PWM_BITS-1:0] CNT_LAST = PWM_BITS'(level_max(PWM_BITS) - 1);
    localparam int                  PW       = $clog2(RAMP_DIV);
    localparam logic [PW-1:0]       PRE_LAST = PW'(RAMP_DIV - 1);

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PW-1:0]       presc;
    logic                tick;
    logic [N_CH-1:0]     ramping;

    assign tick = enable && presc == PRE_LAST;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
            presc   <= '0;
            busy    <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt == CNT_LAST ? '0 : pwm_cnt + 1'b1;
            presc   <= !enable ? presc : tick ? '0 : presc + 1'b1;
            busy    <= |ramping;
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        led_fade_channel #(.PWM_BITS(PWM_BITS)) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .pattern (pattern_in[c]),
            .tick    (tick),
            .pwm_cnt (pwm_cnt),
            .led     (led_out[c]),
            .ramping (ramping[c])
        );
    end
endmodule

// File: tb/tb_led_fader.sv
// tb_led_fader: directed scoreboard bench; stimulus queues expectations, a monitor consumes and compares them
module tb_led_fader;
    typedef enum {K_HOLD, K_DUTY, K_BSPAN, K_BUSY} kind_e;
    typedef struct {
        kind_e kind;
        int    ch;
        int    n;
        int    exp_a;
        int    exp_b;
        string name;
    } item_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b1;
    logic [4:0] pattern_in = 5'b0;
    logic [4:0] led_out;
    logic       busy;
    logic       kick = 1'b0;

    item_t q[$];
    int    n_checks = 0;
    int    n_pass = 0;
    bit    mon_active = 1'b0;

    led_fader #(.N_CH(5), .PWM_BITS(4), .RAMP_DIV(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pattern_in (pattern_in),
        .enable     (enable),
        .led_out    (led_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    initial begin
        item_t it;
        int    cnt;
        int    w;
        int    act;
        logic [5:0] want;
        forever begin
            @(posedge clk or posedge kick);
            #1;
            if (q.size() != 0) begin
                it = q.pop_front();
                mon_active = 1'b1;
                case (it.kind)
                    K_HOLD: begin
                        want = 6'(it.exp_b * 32 + it.exp_a);
                        act  = int'(want);
                        for (int i = 0; i < it.n; i++) begin
                            if (i > 0) begin
                                @(posedge clk);
                                #1;
                            end
                            if ({busy, led_out} !== want && act == int'(want)) act = int'({busy, led_out});
                        end
                        check(it.name, act, int'(want));
                    end
                    K_DUTY: begin
                        cnt = 0;
                        for (int i = 0; i < it.n; i++) begin
                            if (i > 0) begin
                                @(posedge clk);
                                #1;
                            end
                            if (led_out[it.ch] === 1'b1) cnt++;
                        end
                        check(it.name, cnt, it.exp_a);
                    end
                    K_BUSY: check(it.name, busy === 1'b1 ? 1 : 0, it.exp_a);
                    K_BSPAN: begin
                        w = 0;
                        while (busy !== 1'b1 && w < 20) begin
                            @(posedge clk);
                            #1;
                            w++;
                        end
                        cnt = 0;
                        while (busy === 1'b1 && cnt < 400) begin
                            cnt++;
                            @(posedge clk);
                            #1;
                        end
                        check(it.name, cnt, it.exp_a);
                    end
                    default: check("bad_item", 0, 1);
                endcase
                mon_active = 1'b0;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input kind_e k, input int ch, input int n, input int a, input int b, input string nm);
        item_t it;
        it.kind  = k;
        it.ch    = ch;
        it.n     = n;
        it.exp_a = a;
        it.exp_b = b;
        it.name  = nm;
        q.push_back(it);
    endtask

    task automatic drain();
        int w = 0;
        while ((q.size() != 0 || mon_active) && w < 3000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 3000) begin
            n_checks++;
            $display("FAIL drain: %0d items still pending, expected 0", q.size());
        end
    endtask

    // leaves the bench at the negedge just before the first active edge after release
    task automatic do_reset(input logic [4:0] pat);
        @(negedge clk);
        rst_n      = 1'b0;
        enable     = 1'b1;
        pattern_in = 5'b0;
        cyc(3);
        rst_n      = 1'b1;
        pattern_in = pat;
    endtask

    initial begin
        do_reset(5'b00000);
        push(K_HOLD, 0, 1000, 0, 0, "idle_quiet");
        drain();

        do_reset(5'b00001);
        push(K_BSPAN, 0, 0, 59, 0, "ramp_up_busy_cycles");
        push(K_HOLD, 0, 30, 1, 0, "full_on_hold");
        drain();

        do_reset(5'b00001);
        cyc(26);
        enable = 1'b0;
        push(K_BUSY, 0, 1, 1, 0, "frozen_busy");
        repeat (3) push(K_DUTY, 0, 15, 6, 0, "duty_level6");
        drain();

        do_reset(5'b00001);
        cyc(30);
        enable = 1'b0;
        repeat (14) push(K_DUTY, 0, 15, 7, 0, "duty_level7_frozen");
        drain();
        enable = 1'b1;
        cyc(2);
        enable = 1'b0;
        push(K_DUTY, 0, 15, 8, 0, "resume_level8");
        drain();

        do_reset(5'b00001);
        cyc(37);
        pattern_in = 5'b00000;
        cyc(3);
        enable = 1'b0;
        push(K_DUTY, 0, 15, 8, 0, "reversed_level8");
        drain();
        enable = 1'b1;
        push(K_BSPAN, 0, 0, 32, 0, "fall_busy_cycles");
        push(K_HOLD, 0, 20, 0, 0, "fall_off_hold");
        drain();

        do_reset(5'b00011);
        cyc(42);
        #2 rst_n = 1'b0;
        push(K_HOLD, 0, 1, 0, 0, "async_reset_clears");
        kick = 1'b1;
        #1 kick = 1'b0;
        drain();
        cyc(2);
        rst_n = 1'b1;
        cyc(9);
        enable = 1'b0;
        push(K_DUTY, 0, 15, 2, 0, "restart_ch0_level2");
        push(K_DUTY, 1, 15, 2, 0, "restart_ch1_level2");
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end
endmodule
